// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte valid/ack handshake between uart_rx and its consumer
interface uart_rx_if;
   logic [7:0] dout;
   logic       dout_vld;
   logic       dout_ack;

   modport master (output dout, output dout_vld, input dout_ack);
   modport slave  (input dout, input dout_vld, output dout_ack);
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with centre sampling, valid/ack delivery, framing and overrun pulses
module uart_rx #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      rx,
   uart_rx_if.master bus,
   output logic      frame_err,
   output logic      overrun,
   output logic      busy
);

   localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BRK
   } state_t;

   state_t      state_q;
   logic [15:0] cnt_q;
   logic [2:0]  idx_q;
   logic [7:0]  shift_q;
   logic        sync1_q;
   logic        sync2_q;
   logic [7:0]  dout_q;
   logic        dout_vld_q;
   logic        frame_err_q;
   logic        overrun_q;
   logic        busy_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         dout_q      <= '0;
         dout_vld_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         sync1_q     <= rx;
         sync2_q     <= sync1_q;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;

         // A delivery later in this block overrides the ack-driven clear.
         if (dout_vld_q && bus.dout_ack) begin
            dout_vld_q <= 1'b0;
         end

         case (state_q)
            S_IDLE: begin
               if (!sync2_q) begin
                  state_q <= S_START;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            S_START: begin
               if (cnt_q == HALF) begin
                  cnt_q <= '0;
                  idx_q <= '0;
                  if (!sync2_q) begin
                     state_q <= S_DATA;
                  end else begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            S_DATA: begin
               if (cnt_q == LAST) begin
                  shift_q <= {sync2_q, shift_q[7:1]};
                  cnt_q   <= '0;
                  idx_q   <= idx_q + 3'd1;
                  if (idx_q == 3'd7) begin
                     state_q <= S_STOP;
                  end
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            S_STOP: begin
               if (cnt_q == LAST) begin
                  cnt_q <= '0;
                  if (sync2_q) begin
                     dout_q     <= shift_q;
                     dout_vld_q <= 1'b1;
                     overrun_q  <= dout_vld_q && !bus.dout_ack;
                     state_q    <= S_IDLE;
                     busy_q     <= 1'b0;
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= S_BRK;
                  end
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            S_BRK: begin
               // Held-low break: wait for the line to recover, one frame_err only.
               if (sync2_q) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.dout     = dout_q;
   assign bus.dout_vld = dout_vld_q;
   assign frame_err    = frame_err_q;
   assign overrun      = overrun_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at 16 clocks per bit
module tb_uart_rx;
   localparam int CPB = 16;
   localparam int LAT = 3 + (CPB / 2 - 1) + 9 * CPB;

   typedef struct {
      int         cyc;
      bit         frame;
      logic [7:0] data;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx  = 1'b1;
   logic frame_err, overrun, busy;

   uart_rx_if u_if ();

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .bus       (u_if),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int  cyc = 0;
   int  checks = 0;
   int  failures = 0;
   bit  auto_ack = 1'b1;
   ev_t q[$];
   ev_t e;
   bit  exp_vld = 1'b0;
   logic [7:0] exp_dout = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
      end
   endfunction

   // Consumer that acks one cycle after seeing a byte.
   always @(negedge clk) begin
      if (auto_ack) u_if.dout_ack = u_if.dout_vld;
   end

   // Monitor: pops expected events by cycle and tracks the handshake model.
   always @(posedge clk) begin
      bit ack_s, rst_s, ev, fe_e, ov_e;
      ack_s = u_if.dout_ack;
      rst_s = rst;
      #1;
      if (rst_s) begin
         q.delete();
         exp_vld  = 1'b0;
         exp_dout = 8'h00;
         chk("rst_vld", int'(u_if.dout_vld), 0);
         chk("rst_dout", int'(u_if.dout), 0);
         chk("rst_frame_err", int'(frame_err), 0);
         chk("rst_overrun", int'(overrun), 0);
         chk("rst_busy", int'(busy), 0);
      end else begin
         while (q.size() > 0 && q[0].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL missed_event: event due at cycle %0d not seen, now %0d", q[0].cyc, cyc);
            void'(q.pop_front());
         end
         ev   = 1'b0;
         ov_e = 1'b0;
         if (q.size() > 0 && q[0].cyc == cyc) begin
            e  = q.pop_front();
            ev = 1'b1;
         end
         fe_e = ev && e.frame;
         if (ev && !e.frame) begin
            ov_e     = exp_vld && !ack_s;
            exp_vld  = 1'b1;
            exp_dout = e.data;
         end else if (exp_vld && ack_s) begin
            exp_vld = 1'b0;
         end
         chk("dout_vld", int'(u_if.dout_vld), int'(exp_vld));
         chk("frame_err", int'(frame_err), int'(fe_e));
         chk("overrun", int'(overrun), int'(ov_e));
         if (exp_vld) chk("dout", int'(u_if.dout), int'(exp_dout));
      end
   end

   // Called right after a negedge; returns right after the negedge ending the stop bit.
   task automatic send_frame(input logic [7:0] d, input bit stop, input bit expect_ev);
      logic [9:0] b;
      ev_t        x;
      b = {stop, d, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = b[i];
         if (i == 0 && expect_ev) begin
            x.cyc   = cyc + 1 + LAT;
            x.frame = !stop;
            x.data  = d;
            q.push_back(x);
         end
         repeat (CPB) @(negedge clk);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() > 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", q.size(), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int         cnt;
      int         target;
      logic [7:0] d;
      logic [9:0] b;

      u_if.dout_ack = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Single 0xA5, acked one cycle after delivery
      auto_ack = 1'b0;
      send_frame(8'hA5, 1'b1, 1'b1);
      u_if.dout_ack = 1'b1;
      @(negedge clk);
      u_if.dout_ack = 1'b0;
      chk("a5_vld_after_ack", int'(u_if.dout_vld), 0);
      auto_ack = 1'b1;
      repeat (20) @(negedge clk);

      // Back-to-back frames with zero idle bits
      send_frame(8'h00, 1'b1, 1'b1);
      send_frame(8'hFF, 1'b1, 1'b1);
      repeat (40) @(negedge clk);

      // Start-bit glitch of 5 clocks
      rx = 1'b0;
      repeat (5) @(negedge clk);
      rx = 1'b1;
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (busy) cnt++;
      end
      chk("glitch_busy_seen", int'(cnt > 0), 1);
      chk("glitch_busy_max", int'(cnt <= 9), 1);
      repeat (10) @(negedge clk);

      // Framing error followed by a held-low break
      send_frame(8'h3C, 1'b0, 1'b1);
      cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (!busy) cnt++;
      end
      chk("brk_busy_low_cycles", cnt, 0);
      rx = 1'b1;
      repeat (4) @(negedge clk);
      chk("brk_exit_busy", int'(busy), 0);
      repeat (16) @(negedge clk);
      send_frame(8'h81, 1'b1, 1'b1);
      repeat (20) @(negedge clk);

      // Random bytes with random idle gaps, including none
      repeat (12) begin
         d = 8'($urandom);
         cnt = int'($urandom_range(0, 40));
         send_frame(d, 1'b1, 1'b1);
         repeat (cnt) @(negedge clk);
      end
      repeat (20) @(negedge clk);
      drain();

      // Overrun: 0x11 never acked, then 0x22
      auto_ack = 1'b0;
      @(negedge clk);
      u_if.dout_ack = 1'b0;
      send_frame(8'h11, 1'b1, 1'b1);
      repeat (10) @(negedge clk);
      send_frame(8'h22, 1'b1, 1'b1);
      repeat (5) @(negedge clk);
      chk("ovr_dout", int'(u_if.dout), 8'h22);
      chk("ovr_vld", int'(u_if.dout_vld), 1);

      // Ack landing on the delivery edge: no overrun
      repeat (10) @(negedge clk);
      target = cyc + 1 + LAT;
      fork
         send_frame(8'h33, 1'b1, 1'b1);
         begin
            while (cyc != target - 1) @(negedge clk);
            u_if.dout_ack = 1'b1;
            @(negedge clk);
            u_if.dout_ack = 1'b0;
         end
      join
      repeat (5) @(negedge clk);
      chk("ack_same_dout", int'(u_if.dout), 8'h33);
      chk("ack_same_vld", int'(u_if.dout_vld), 1);

      // Reset in the middle of data bit 4 of 0x5A
      repeat (10) @(negedge clk);
      b = {1'b1, 8'h5A, 1'b0};
      for (int i = 0; i < 6; i++) begin
         rx = b[i];
         repeat ((i == 5) ? CPB / 2 : CPB) @(negedge clk);
      end
      chk("pre_rst_busy", int'(busy), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      rx  = 1'b1;
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_vld", int'(u_if.dout_vld), 0);
      chk("mid_rst_dout", int'(u_if.dout), 0);
      repeat (100) @(negedge clk);
      auto_ack = 1'b1;
      send_frame(8'hC3, 1'b1, 1'b1);
      repeat (20) @(negedge clk);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
